arith_iter_unit: RTL and testbench
==================================

// Module: arith_iter_unit
//
// PURPOSE
// Multi-cycle integer arithmetic unit: unsigned multiply (shift-add) or integer square root (digit-by-digit).
// Parametrised successor of the single-cycle mul/sqrt blocks.
// Adds start/busy/done handshake, remainder/exact reporting and a width parameter.
// Sits beside the ALU; the sequencer issues one operation at a time and waits for done.
//
// PARAMETERS
// WIDTH  8  operand width in bits; must be even and >= 4 (elaboration error otherwise)
//
// PORTS
// clk     in   1        rising-edge clock
// rst     in   1        synchronous active-high reset
// start   in   1        request; accepted only when busy==0
// mode    in   1        0 = MUL (op_a*op_b), 1 = SQRT (isqrt(op_a); op_b ignored)
// op_a    in   WIDTH    operand A, captured on accepted start
// op_b    in   WIDTH    operand B, captured on accepted start
// busy    out  1        1 while in CALC
// done    out  1        1-cycle pulse: results valid
// res_hi  out  WIDTH    MUL: product[2W-1:W]; SQRT: remainder op_a - root^2, zero-extended
// res_lo  out  WIDTH    MUL: product[W-1:0]; SQRT: root in [W/2-1:0], upper bits 0
// carry   out  1        MUL: |res_hi; SQRT: 0
// exact   out  1        SQRT: remainder==0; MUL: 1
//
// BEHAVIOUR
// - Reset: state IDLE; busy=0, done=0, res_hi=0, res_lo=0, carry=0, exact=0; internal regs cleared.
// - Reset mid-operation aborts with no done pulse; reset dominates start in the same cycle.
// - FSM states: IDLE, CALC, DONE.
//   - IDLE --start--> CALC: latch mode/op_a/op_b; iteration counter loaded with N.
//   - N = WIDTH for MUL, WIDTH/2 for SQRT.
//   - CALC: one iteration per cycle; busy=1; start ignored (no queueing).
//   - CALC --counter hits 0--> DONE.
//   - DONE: done=1 for exactly one cycle; result outputs updated on entry to DONE.
//   - DONE --start--> CALC (back-to-back accepted); DONE --!start--> IDLE.
// - Latency: start sampled at edge 0 -> done high in the cycle after edge N+1.
//   - WIDTH=8: MUL done after edge 9; SQRT done after edge 5.
// - Result outputs hold their last value until the next DONE entry or reset; they do not change during CALC.
// - MUL: full 2*WIDTH product; shift-add over op_b bits LSB first into a 2*WIDTH accumulator; no truncation.
// - SQRT: classic restoring bit-pair algorithm.
//   - Each iteration consumes 2 MSBs of op_a.
//   - trial = (rem<<2 | pair) - (root<<2 | 1).
//   - If trial >= 0: rem=trial, root=root<<1|1; else rem=rem<<2|pair, root=root<<1.
//   - Remainder width W/2+1 bits.
//   - root = floor(sqrt(op_a)) for all op_a including 0 and 2^W-1.
// - op_a/op_b changes after the accepted start do not affect the running operation.
// - mode changes after the accepted start do not affect the running operation.
// - start while busy==1: no effect, no error flag.
//
// TESTING
// 1. WIDTH=8, MUL 255*255 -> done after 9 edges; res_hi=0xFE, res_lo=0x01, carry=1, exact=1.
// 2. MUL 0x0F*0x03 -> res_hi=0x00, res_lo=0x2D, carry=0; MUL 0*0xAB -> 0, carry=0.
// 3. SQRT 144 -> done after 5 edges; res_lo=12, res_hi=0, exact=1.
//    SQRT 200 -> res_lo=14, res_hi=4, exact=0.
//    SQRT 0 -> 0/0, exact=1.
//    SQRT 255 -> 15, rem 30.
// 4. start pulsed every cycle during CALC -> single op, single done.
//    start held high through DONE -> back-to-back second op; busy high the cycle after DONE.
// 5. rst asserted 3 cycles into MUL -> next cycle busy=0, no done, outputs 0.
//    A new start then completes normally.
// 6. WIDTH=16, 1000 random MUL/SQRT ops vs reference model.
//    Check latency, done width==1, and result stability between ops.
//    Include op_a=0xFFFF -> root 255, rem 510.

Source files
------------

// File: rtl/arith_iter_unit.sv
// Multi-cycle unsigned multiply (shift-add) / integer square root (restoring bit-pair).
// Latency: start at edge 0 -> done high after edge N+1 (N = WIDTH for MUL, WIDTH/2 for SQRT).
// Backpressure: none; start is ignored while busy, and results hold until the next DONE entry.
module arith_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             carry,
  output logic             exact
);

  localparam int HW = WIDTH / 2;           // root width
  localparam int RW = HW + 1;              // remainder width
  localparam int TW = HW + 3;              // trial width: {rem, pair} and {0, root, 01}
  localparam int CW = $clog2(WIDTH + 1);   // iteration counter width
  localparam logic [CW-1:0] N_MUL = CW'(WIDTH);
  localparam logic [CW-1:0] N_SQ  = CW'(HW);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("arith_iter_unit: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;
  logic   accept;   // operation captured this edge
  logic   iter;     // one iteration performed this edge
  logic   finish;   // last CALC cycle: publish results

  logic                 mode_q;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     rad;
  logic [RW-1:0]        rem;
  logic [HW-1:0]        root;

  logic [TW-1:0]        sq_cur;
  logic [TW-1:0]        sq_sub;
  logic [RW-1:0]        sq_dif;
  logic                 sq_ge;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    iter      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          iter = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Square-root trial subtraction; the true difference always fits the remainder width
  always_comb begin
    sq_cur = {rem, rad[WIDTH-1 -: 2]};
    sq_sub = {1'b0, root, 2'b01};
    sq_ge  = (sq_cur >= sq_sub);
    sq_dif = sq_cur[RW-1:0] - sq_sub[RW-1:0];
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      res_hi <= '0;
      res_lo <= '0;
      carry  <= 1'b0;
      exact  <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        cnt    <= mode ? N_SQ : N_MUL;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, op_a};
        mplier <= op_b;
        rad    <= op_a;
        rem    <= '0;
        root   <= '0;
      end else if (iter) begin
        cnt <= cnt - CW'(1);
        if (!mode_q) begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end else begin
          rem  <= sq_ge ? sq_dif : sq_cur[RW-1:0];
          root <= {root[HW-2:0], sq_ge};
          rad  <= rad << 2;
        end
      end
      if (finish) begin
        if (!mode_q) begin
          res_hi <= acc[2*WIDTH-1:WIDTH];
          res_lo <= acc[WIDTH-1:0];
          carry  <= |acc[2*WIDTH-1:WIDTH];
          exact  <= 1'b1;
        end else begin
          res_hi <= {{(WIDTH-RW){1'b0}}, rem};
          res_lo <= {{(WIDTH-HW){1'b0}}, root};
          carry  <= 1'b0;
          exact  <= (rem == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_iter_unit.sv
// Bench for arith_iter_unit: a WIDTH=8 instance for directed cases, a WIDTH=16 instance for random ops.
// Expected results come from plain-arithmetic reference functions, queued at acceptance.
// A negedge monitor pops and checks results, latency, busy and output stability.
module tb_arith_iter_unit;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        carry;
    logic        exact;
    int          due;
  } exp_t;

  logic clk;
  logic        rst_s   [2];
  logic        start_s [2];
  logic        mode_s  [2];
  logic [15:0] a_s     [2];
  logic [15:0] b_s     [2];

  logic        busy8, done8, carry8, exact8;
  logic [7:0]  hi8, lo8;
  logic        busy16, done16, carry16, exact16;
  logic [15:0] hi16, lo16;

  exp_t q0[$];
  exp_t q1[$];
  exp_t last [2];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int next_free [2];
  int busy_end  [2];
  int accepted  [2];
  bit rst_seen  [2];

  arith_iter_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .mode(mode_s[0]),
    .op_a(a_s[0][7:0]), .op_b(b_s[0][7:0]),
    .busy(busy8), .done(done8), .res_hi(hi8), .res_lo(lo8),
    .carry(carry8), .exact(exact8)
  );

  arith_iter_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .mode(mode_s[1]),
    .op_a(a_s[1]), .op_b(b_s[1]),
    .busy(busy16), .done(done16), .res_hi(hi16), .res_lo(lo16),
    .carry(carry16), .exact(exact16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: product split at w bits, or floor(sqrt) found by counting up.
  function automatic exp_t ref_res(input int w, input bit m, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [31:0] mask, p, r, rm;
    mask = (32'd1 << w) - 32'd1;
    e = '0;
    if (!m) begin
      p       = {16'd0, a} * {16'd0, b};
      e.hi    = 16'((p >> w) & mask);
      e.lo    = 16'(p & mask);
      e.carry = (e.hi != 16'd0);
      e.exact = 1'b1;
    end else begin
      r = 0;
      while ((r + 1) * (r + 1) <= {16'd0, a}) r = r + 1;
      rm      = {16'd0, a} - r * r;
      e.hi    = 16'(rm);
      e.lo    = 16'(r);
      e.carry = 1'b0;
      e.exact = (rm == 0);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    vectors = vectors + 1;
    if (act !== req) begin
      miscompares = miscompares + 1;
      $display("FAIL %s dut%0d edge %0d: got %h, required %h", name, g, cyc, act, req);
    end
  endtask

  // Acceptance model: an op is taken when the unit is free; result due N+1 edges later.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int g = 0; g < 2; g++) begin
      int w, n;
      logic [15:0] a, b;
      exp_t e;
      w = (g == 0) ? 8 : 16;
      rst_seen[g] = rst_s[g];
      if (rst_s[g]) begin
        next_free[g] = cyc + 1;
        busy_end[g]  = 0;
      end else if (start_s[g] && cyc >= next_free[g]) begin
        a = (g == 0) ? {8'd0, a_s[g][7:0]} : a_s[g];
        b = (g == 0) ? {8'd0, b_s[g][7:0]} : b_s[g];
        n = mode_s[g] ? w / 2 : w;
        e = ref_res(w, mode_s[g], a, b);
        e.due = cyc + n + 1;
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
        busy_end[g]  = cyc + n + 1;
        next_free[g] = cyc + n + 2;
        accepted[g]  = accepted[g] + 1;
      end
    end
  end

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int g);
    return (g == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int g);
    if (g == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic mon_step(input int g);
    logic        busy, done, carry, exact;
    logic [15:0] hi, lo;
    exp_t e;
    busy  = (g == 0) ? busy8  : busy16;
    done  = (g == 0) ? done8  : done16;
    carry = (g == 0) ? carry8 : carry16;
    exact = (g == 0) ? exact8 : exact16;
    hi    = (g == 0) ? {8'd0, hi8} : hi16;
    lo    = (g == 0) ? {8'd0, lo8} : lo16;
    if (rst_seen[g]) begin
      if (g == 0) q0.delete();
      else        q1.delete();
      last[g] = '0;
    end
    while (qsize(g) > 0 && qfront(g).due < cyc) begin
      chk("done_missing", g, 32'(qfront(g).due), 32'(cyc));
      qpop(g);
    end
    chk("busy", g, 32'(busy), 32'(cyc < busy_end[g]));
    if (done) begin
      if (qsize(g) == 0) begin
        chk("spurious_done", g, 32'(done), 32'd0);
      end else begin
        e = qfront(g);
        qpop(g);
        chk("latency", g, 32'(cyc), 32'(e.due));
        chk("res_hi", g, 32'(hi), 32'(e.hi));
        chk("res_lo", g, 32'(lo), 32'(e.lo));
        chk("carry", g, 32'(carry), 32'(e.carry));
        chk("exact", g, 32'(exact), 32'(e.exact));
        last[g] = e;
      end
    end else begin
      chk("hold", g, {hi, lo}, {last[g].hi, last[g].lo});
      chk("hold_flags", g, 32'({carry, exact}), 32'({last[g].carry, last[g].exact}));
    end
  endtask

  // Monitor: checks both units away from the active edge.
  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int g, input bit m, input logic [15:0] a, input logic [15:0] b, input int gap);
    start_s[g] = 1'b1;
    mode_s[g]  = m;
    a_s[g]     = a;
    b_s[g]     = b;
    tick();
    start_s[g] = 1'b0;
    mode_s[g]  = ~m;
    a_s[g]     = 16'($urandom);
    b_s[g]     = 16'($urandom);
    repeat (gap) tick();
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_s[g] = 1'b1; start_s[g] = 1'b0; mode_s[g] = 1'b0;
      a_s[g] = '0; b_s[g] = '0;
      next_free[g] = 0; busy_end[g] = 0; accepted[g] = 0;
      rst_seen[g] = 1'b0; last[g] = '0;
    end
    repeat (2) tick();
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    tick();

    issue(0, 1'b0, 16'h00FF, 16'h00FF, 12);
    issue(0, 1'b0, 16'h000F, 16'h0003, 12);
    issue(0, 1'b0, 16'h0000, 16'h00AB, 12);
    issue(0, 1'b1, 16'd144,  16'h0000, 8);
    issue(0, 1'b1, 16'd200,  16'h0000, 8);
    issue(0, 1'b1, 16'd0,    16'h0000, 8);
    issue(0, 1'b1, 16'd255,  16'h0000, 8);

    // start high every cycle of the op, released before DONE: one op only
    start_s[0] = 1'b1; mode_s[0] = 1'b0; a_s[0] = 16'h005A; b_s[0] = 16'h003C;
    repeat (10) begin
      tick();
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); mode_s[0] = 1'($urandom);
    end
    start_s[0] = 1'b0;
    repeat (12) tick();

    // start held through DONE: second SQRT accepted back-to-back
    start_s[0] = 1'b1; mode_s[0] = 1'b1; a_s[0] = 16'h00C8;
    repeat (7) begin
      tick();
      a_s[0] = 16'($urandom);
    end
    start_s[0] = 1'b0;
    repeat (12) tick();

    // reset three cycles into a MUL, then a clean op
    issue(0, 1'b0, 16'h00C3, 16'h007E, 2);
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    repeat (3) tick();
    issue(0, 1'b0, 16'h0012, 16'h0034, 12);

    // random traffic on the wide unit
    for (int i = 0; i < 60000 && accepted[1] < 1000; i++) begin
      start_s[1] = ($urandom_range(0, 2) == 0);
      mode_s[1]  = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a_s[1] = 16'hFFFF;
        1:       a_s[1] = 16'h0000;
        default: a_s[1] = 16'($urandom);
      endcase
      b_s[1] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rst_s[1] = ($urandom_range(0, 1499) == 0);
      tick();
    end
    start_s[1] = 1'b0;
    rst_s[1]   = 1'b0;
    issue(1, 1'b1, 16'hFFFF, 16'h0000, 40);

    chk("drain", 0, 32'(q0.size()), 32'd0);
    chk("drain", 1, 32'(q1.size()), 32'd0);
    chk("op_count", 1, 32'(accepted[1] >= 1000), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
